// File: rtl/i2c_regfile_pkg.sv
// Shared types and constants for the I2C slave register file controller.
package i2c_regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PTR   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  localparam int          DEF_NUM_REGS = 16;
  localparam logic [7:0]  TX_IDLE      = 8'hFF;

endpackage

// File: rtl/i2c_regfile_mem.sv
// Register array with a prioritized I2C write port, a host write port and two
// read ports that already reflect writes landing on the same clock edge.
module i2c_regfile_mem #(
  parameter  int NUM_REGS = 16,
  parameter  int DATA_W   = 8,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2c_we,
  input  logic [AW-1:0]     i2c_addr,
  input  logic [DATA_W-1:0] i2c_wdata,
  input  logic              host_we,
  input  logic [AW-1:0]     host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic [AW-1:0]     rd_a_addr,
  output logic [DATA_W-1:0] rd_a_data,
  input  logic [AW-1:0]     rd_b_addr,
  output logic [DATA_W-1:0] rd_b_data,
  output logic              host_lost
);

  logic [DATA_W-1:0] regs [NUM_REGS];

  assign host_lost = host_we && i2c_we && (host_addr == i2c_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (host_we && !host_lost) regs[host_addr] <= host_wdata;
      if (i2c_we)                regs[i2c_addr]  <= i2c_wdata;
    end
  end

  // Read ports return the value the register holds after this edge.
  assign rd_a_data = (i2c_we  && i2c_addr  == rd_a_addr) ? i2c_wdata  :
                     (host_we && host_addr == rd_a_addr) ? host_wdata : regs[rd_a_addr];
  assign rd_b_data = (i2c_we  && i2c_addr  == rd_b_addr) ? i2c_wdata  :
                     (host_we && host_addr == rd_b_addr) ? host_wdata : regs[rd_b_addr];

endmodule

// File: rtl/i2c_slave_regfile_ctrl.sv
// I2C slave register-file controller: pointer/write/read FSM on top of a
// dual-ported register array shared with a host bus.
module i2c_slave_regfile_ctrl
  import i2c_regfile_pkg::*;
#(
  parameter  int                  NUM_REGS = DEF_NUM_REGS,
  parameter  logic [NUM_REGS-1:0] WP_MASK  = '0,
  localparam int                  AW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i2c_start,
  input  logic          i2c_rw,
  input  logic          i2c_stop,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          tx_req,
  output logic [7:0]    tx_data,
  input  logic [AW-1:0] host_addr,
  input  logic          host_wr_en,
  input  logic [7:0]    host_wr_data,
  output logic [7:0]    host_rd_data,
  output logic          host_collision,
  output logic          wr_irq,
  output logic [AW-1:0] last_wr_ptr
);

  state_t        state;
  state_t        st_eff;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_inc;
  logic [AW-1:0] tx_addr;
  logic          wr_flag;
  logic          wr_flag_nxt;
  logic          i2c_we;
  logic          host_lost;
  logic [7:0]    host_rd;
  logic [7:0]    tx_rd;
  logic          unused_rx_hi;

  assign unused_rx_hi = ^rx_data;

  // A start is acted on first, so same-cycle rx_valid/tx_req see the new state.
  always_comb begin
    st_eff = state;
    if (i2c_start) st_eff = i2c_rw ? ST_READ : ST_PTR;
  end

  assign ptr_inc     = ptr + AW'(1);
  assign i2c_we      = rx_valid && (st_eff == ST_WRITE) && !WP_MASK[ptr];
  assign tx_addr     = (st_eff == ST_READ && tx_req) ? ptr_inc : ptr;
  assign wr_flag_nxt = (wr_flag && !i2c_start) || i2c_we;

  i2c_regfile_mem #(
    .NUM_REGS (NUM_REGS),
    .DATA_W   (8)
  ) u_mem (
    .clk        (clk),
    .rst        (rst),
    .i2c_we     (i2c_we),
    .i2c_addr   (ptr),
    .i2c_wdata  (rx_data),
    .host_we    (host_wr_en),
    .host_addr  (host_addr),
    .host_wdata (host_wr_data),
    .rd_a_addr  (host_addr),
    .rd_a_data  (host_rd),
    .rd_b_addr  (tx_addr),
    .rd_b_data  (tx_rd),
    .host_lost  (host_lost)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      ptr            <= '0;
      tx_data        <= '0;
      host_rd_data   <= '0;
      host_collision <= 1'b0;
      wr_irq         <= 1'b0;
      last_wr_ptr    <= '0;
      wr_flag        <= 1'b0;
    end else begin
      host_rd_data   <= host_rd;
      host_collision <= host_lost;
      wr_irq         <= i2c_stop && wr_flag_nxt;
      wr_flag        <= i2c_stop ? 1'b0 : wr_flag_nxt;
      if (i2c_we) last_wr_ptr <= ptr;

      state <= st_eff;
      case (st_eff)
        ST_PTR: begin
          if (rx_valid) begin
            ptr   <= rx_data[AW-1:0];
            state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (rx_valid) ptr <= ptr_inc;
        end
        ST_READ: begin
          if (tx_req) ptr <= ptr_inc;
          if (tx_req || i2c_start) tx_data <= tx_rd;
        end
        default: ;
      endcase

      if (tx_req && st_eff != ST_READ) tx_data <= TX_IDLE;
      // Stop is applied last; ptr is retained across transactions.
      if (i2c_stop) state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile_ctrl.sv
// Randomized self-checking bench for i2c_slave_regfile_ctrl against an
// array/pointer reference model of the register file.
module tb_i2c_slave_regfile_ctrl;

  localparam logic [15:0] WP = 16'h0004;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i2c_start = 1'b0, i2c_rw = 1'b0, i2c_stop = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0, tx_req = 1'b0;
  logic [7:0] tx_data;
  logic [3:0] host_addr = 4'h0;
  logic       host_wr_en = 1'b0;
  logic [7:0] host_wr_data = 8'h00;
  logic [7:0] host_rd_data;
  logic       host_collision, wr_irq;
  logic [3:0] last_wr_ptr;

  int checks = 0;
  int failures = 0;

  logic [7:0] mdl [16];
  logic [3:0] mptr;
  logic [3:0] mlast;

  i2c_slave_regfile_ctrl #(.NUM_REGS(16), .WP_MASK(WP)) dut (
    .clk(clk), .rst(rst), .i2c_start(i2c_start), .i2c_rw(i2c_rw), .i2c_stop(i2c_stop),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_req(tx_req), .tx_data(tx_data),
    .host_addr(host_addr), .host_wr_en(host_wr_en), .host_wr_data(host_wr_data),
    .host_rd_data(host_rd_data), .host_collision(host_collision), .wr_irq(wr_irq),
    .last_wr_ptr(last_wr_ptr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic do_start(input logic rw);
    i2c_start = 1'b1; i2c_rw = rw; tick(); i2c_start = 1'b0; i2c_rw = 1'b0;
  endtask
  task automatic do_stop(); i2c_stop = 1'b1; tick(); i2c_stop = 1'b0; endtask
  task automatic do_rx(input logic [7:0] b); rx_data = b; rx_valid = 1'b1; tick(); rx_valid = 1'b0; endtask
  task automatic do_txreq(); tx_req = 1'b1; tick(); tx_req = 1'b0; endtask

  task automatic host_wr(input logic [3:0] a, input logic [7:0] d);
    host_addr = a; host_wr_data = d; host_wr_en = 1'b1; tick(); host_wr_en = 1'b0;
    mdl[a] = d;
  endtask
  task automatic host_rd(input logic [3:0] a, output logic [7:0] d);
    host_addr = a; tick(); d = host_rd_data;
  endtask

  // Bus-level write: start(rw=0), pointer byte, data bytes; model applies the
  // register-file rules (protected registers skipped, pointer wraps mod 16).
  task automatic i2c_write(input logic [7:0] p, input logic [7:0] data[$], output bit wrote);
    wrote = 1'b0;
    do_start(1'b0);
    do_rx(p);
    mptr = p[3:0];
    foreach (data[i]) begin
      do_rx(data[i]);
      if (!WP[mptr]) begin mdl[mptr] = data[i]; mlast = mptr; wrote = 1'b1; end
      mptr = mptr + 4'd1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] d;
    repeat (3) tick();
    checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    checks++; if (host_rd_data !== 8'h00) begin failures++; $display("FAIL rst_host_rd got=%h exp=00", host_rd_data); end
    checks++; if (host_collision !== 1'b0 || wr_irq !== 1'b0) begin failures++; $display("FAIL rst_pulses got=%b%b exp=00", host_collision, wr_irq); end
    checks++; if (last_wr_ptr !== 4'h0) begin failures++; $display("FAIL rst_last_wr_ptr got=%h exp=0", last_wr_ptr); end
    rst = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    mptr = 4'h0; mlast = 4'h0;
    for (int i = 0; i < 4; i++) begin
      host_rd(4'($urandom_range(0, 15)), d);
      checks++; if (d !== 8'h00) begin failures++; $display("FAIL rst_reg got=%h exp=00", d); end
    end
  endtask

  task automatic preload();
    for (int i = 0; i < 16; i++) host_wr(4'(i), 8'(8'h80 + i));
  endtask

  task automatic test_basic_write();
    logic [7:0] q[$];
    logic [7:0] d;
    bit wrote;
    q = {8'hA5, 8'h5A};
    i2c_write(8'h03, q, wrote);
    do_stop();
    checks++; if (wr_irq !== wrote) begin failures++; $display("FAIL basic_irq got=%b exp=%b", wr_irq, wrote); end
    tick();
    checks++; if (wr_irq !== 1'b0) begin failures++; $display("FAIL basic_irq_len got=%b exp=0", wr_irq); end
    checks++; if (last_wr_ptr !== 4'd4) begin failures++; $display("FAIL basic_last got=%h exp=4", last_wr_ptr); end
    host_rd(4'd3, d);
    checks++; if (d !== 8'hA5) begin failures++; $display("FAIL basic_reg3 got=%h exp=a5", d); end
    host_rd(4'd4, d);
    checks++; if (d !== 8'h5A) begin failures++; $display("FAIL basic_reg4 got=%h exp=5a", d); end
    do_start(1'b1);
    checks++; if (tx_data !== mdl[mptr] || mptr !== 4'd5) begin failures++; $display("FAIL basic_ptr5 got=%h exp=%h", tx_data, mdl[5]); end
    do_stop();
    checks++; if (wr_irq !== 1'b0) begin failures++; $display("FAIL basic_rd_irq got=%b exp=0", wr_irq); end
  endtask

  task automatic test_repeated_start_read();
    logic [7:0] q[$];
    bit wrote;
    host_wr(4'd5, 8'h11);
    host_wr(4'd6, 8'h22);
    q.delete();
    i2c_write(8'h05, q, wrote);
    do_start(1'b1);
    checks++; if (tx_data !== 8'h11) begin failures++; $display("FAIL rs_tx0 got=%h exp=11", tx_data); end
    do_txreq();
    checks++; if (tx_data !== 8'h22) begin failures++; $display("FAIL rs_tx1 got=%h exp=22", tx_data); end
    do_txreq();
    checks++; if (tx_data !== mdl[7]) begin failures++; $display("FAIL rs_tx2 got=%h exp=%h", tx_data, mdl[7]); end
    mptr = 4'd7;
    do_stop();
    checks++; if (wr_irq !== 1'b0) begin failures++; $display("FAIL rs_irq got=%b exp=0", wr_irq); end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] d;
    bit wrote;
    q = {8'h01, 8'h02};
    i2c_write(8'hFF, q, wrote);
    do_stop();
    checks++; if (wr_irq !== 1'b1) begin failures++; $display("FAIL wrap_irq got=%b exp=1", wr_irq); end
    checks++; if (last_wr_ptr !== 4'd0) begin failures++; $display("FAIL wrap_last got=%h exp=0", last_wr_ptr); end
    host_rd(4'd15, d);
    checks++; if (d !== 8'h01) begin failures++; $display("FAIL wrap_reg15 got=%h exp=01", d); end
    host_rd(4'd0, d);
    checks++; if (d !== 8'h02) begin failures++; $display("FAIL wrap_reg0 got=%h exp=02", d); end
    do_start(1'b1);
    checks++; if (tx_data !== mdl[1]) begin failures++; $display("FAIL wrap_ptr1 got=%h exp=%h", tx_data, mdl[1]); end
    do_stop();
  endtask

  task automatic test_write_protect();
    logic [7:0] q[$];
    logic [7:0] d;
    bit wrote;
    q = {8'h77, 8'h88};
    i2c_write(8'h02, q, wrote);
    do_stop();
    checks++; if (wr_irq !== wrote) begin failures++; $display("FAIL wp_irq got=%b exp=%b", wr_irq, wrote); end
    checks++; if (last_wr_ptr !== 4'd3) begin failures++; $display("FAIL wp_last got=%h exp=3", last_wr_ptr); end
    host_rd(4'd2, d);
    checks++; if (d !== 8'h82) begin failures++; $display("FAIL wp_reg2 got=%h exp=82", d); end
    host_rd(4'd3, d);
    checks++; if (d !== 8'h88) begin failures++; $display("FAIL wp_reg3 got=%h exp=88", d); end
    q = {8'h55};
    i2c_write(8'h02, q, wrote);
    do_stop();
    checks++; if (wr_irq !== wrote) begin failures++; $display("FAIL wp_only_irq got=%b exp=%b", wr_irq, wrote); end
    host_wr(4'd2, 8'h99);
    host_rd(4'd2, d);
    checks++; if (d !== 8'h99) begin failures++; $display("FAIL wp_host_reg2 got=%h exp=99", d); end
  endtask

  task automatic test_collision();
    logic [7:0] d;
    do_start(1'b0);
    do_rx(8'h01);
    rx_data = 8'h44; rx_valid = 1'b1;
    host_addr = 4'd1; host_wr_data = 8'h33; host_wr_en = 1'b1;
    tick();
    rx_valid = 1'b0; host_wr_en = 1'b0;
    mdl[1] = 8'h44;
    checks++; if (host_collision !== 1'b1) begin failures++; $display("FAIL coll_pulse got=%b exp=1", host_collision); end
    do_rx(8'h66);
    checks++; if (host_collision !== 1'b0) begin failures++; $display("FAIL coll_len got=%b exp=0", host_collision); end
    rx_data = 8'h77; rx_valid = 1'b1;
    host_addr = 4'd9; host_wr_data = 8'h5C; host_wr_en = 1'b1;
    tick();
    rx_valid = 1'b0; host_wr_en = 1'b0;
    mdl[3] = 8'h77; mdl[9] = 8'h5C; mptr = 4'd4; mlast = 4'd3;
    checks++; if (host_collision !== 1'b0) begin failures++; $display("FAIL coll_diff got=%b exp=0", host_collision); end
    do_stop();
    checks++; if (wr_irq !== 1'b1) begin failures++; $display("FAIL coll_irq got=%b exp=1", wr_irq); end
    host_rd(4'd1, d);
    checks++; if (d !== 8'h44) begin failures++; $display("FAIL coll_reg1 got=%h exp=44", d); end
    host_rd(4'd3, d);
    checks++; if (d !== 8'h77) begin failures++; $display("FAIL coll_reg3 got=%h exp=77", d); end
    host_rd(4'd9, d);
    checks++; if (d !== 8'h5C) begin failures++; $display("FAIL coll_reg9 got=%h exp=5c", d); end
    checks++; if (last_wr_ptr !== 4'd3) begin failures++; $display("FAIL coll_last got=%h exp=3", last_wr_ptr); end
  endtask

  task automatic test_tx_idle();
    do_start(1'b1);
    checks++; if (tx_data !== mdl[mptr]) begin failures++; $display("FAIL idle_rd got=%h exp=%h", tx_data, mdl[mptr]); end
    do_stop();
    do_txreq();
    checks++; if (tx_data !== 8'hFF) begin failures++; $display("FAIL idle_tx got=%h exp=ff", tx_data); end
    do_start(1'b1);
    do_start(1'b0);
    do_rx(8'h00);
    mptr = 4'h0;
    do_txreq();
    checks++; if (tx_data !== 8'hFF) begin failures++; $display("FAIL write_tx got=%h exp=ff", tx_data); end
    do_stop();
    checks++; if (wr_irq !== 1'b0) begin failures++; $display("FAIL idle_irq got=%b exp=0", wr_irq); end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    logic [7:0] d;
    logic [3:0] a;
    bit wrote;
    int n;
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 2))
        0: begin
          q.delete();
          n = $urandom_range(0, 5);
          for (int k = 0; k < n; k++) q.push_back(8'($urandom));
          i2c_write(8'($urandom), q, wrote);
          do_stop();
          checks++; if (wr_irq !== wrote) begin failures++; $display("FAIL rnd_irq it=%0d got=%b exp=%b", it, wr_irq, wrote); end
          checks++; if (last_wr_ptr !== mlast) begin failures++; $display("FAIL rnd_last it=%0d got=%h exp=%h", it, last_wr_ptr, mlast); end
        end
        1: begin
          do_start(1'b1);
          checks++; if (tx_data !== mdl[mptr]) begin failures++; $display("FAIL rnd_rd0 it=%0d got=%h exp=%h", it, tx_data, mdl[mptr]); end
          n = $urandom_range(0, 4);
          for (int k = 0; k < n; k++) begin
            if ($urandom_range(0, 1) == 1) do_rx(8'($urandom));
            do_txreq();
            mptr = mptr + 4'd1;
            checks++; if (tx_data !== mdl[mptr]) begin failures++; $display("FAIL rnd_rd it=%0d got=%h exp=%h", it, tx_data, mdl[mptr]); end
          end
          do_stop();
          checks++; if (wr_irq !== 1'b0) begin failures++; $display("FAIL rnd_rd_irq it=%0d got=%b exp=0", it, wr_irq); end
        end
        default: begin
          a = 4'($urandom);
          host_wr(a, 8'($urandom));
          host_rd(a, d);
          checks++; if (d !== mdl[a]) begin failures++; $display("FAIL rnd_host it=%0d got=%h exp=%h", it, d, mdl[a]); end
        end
      endcase
    end
    for (int i = 0; i < 16; i++) begin
      host_rd(4'(i), d);
      checks++; if (d !== mdl[i]) begin failures++; $display("FAIL rnd_final reg%0d got=%h exp=%h", i, d, mdl[i]); end
    end
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] d;
    do_start(1'b0);
    do_rx(8'h06);
    do_txreq();
    do_rx(8'hAB);
    do_rx(8'hCD);
    rst = 1'b1;
    #2;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    mptr = 4'h0; mlast = 4'h0;
    checks++; if (tx_data !== 8'h00 || host_rd_data !== 8'h00) begin failures++; $display("FAIL mid_rst_data got=%h/%h exp=00/00", tx_data, host_rd_data); end
    checks++; if (last_wr_ptr !== 4'h0) begin failures++; $display("FAIL mid_rst_last got=%h exp=0", last_wr_ptr); end
    checks++; if (wr_irq !== 1'b0 || host_collision !== 1'b0) begin failures++; $display("FAIL mid_rst_pulses got=%b%b exp=00", wr_irq, host_collision); end
    tick();
    rst = 1'b0;
    tick();
    do_rx(8'h12);
    do_stop();
    checks++; if (wr_irq !== 1'b0) begin failures++; $display("FAIL mid_rst_irq got=%b exp=0", wr_irq); end
    host_rd(4'd6, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL mid_rst_reg6 got=%h exp=00", d); end
    host_rd(4'd7, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL mid_rst_reg7 got=%h exp=00", d); end
    host_rd(4'd0, d);
    checks++; if (d !== 8'h00) begin failures++; $display("FAIL mid_rst_reg0 got=%h exp=00", d); end
    host_wr(4'd0, 8'h5E);
    do_start(1'b1);
    checks++; if (tx_data !== mdl[0]) begin failures++; $display("FAIL mid_rst_ptr got=%h exp=%h", tx_data, mdl[0]); end
    do_stop();
  endtask

  initial begin
    test_reset();
    preload();
    test_basic_write();
    test_repeated_start_read();
    test_wrap();
    test_write_protect();
    test_collision();
    test_tx_idle();
    test_random();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regfile_ctrl.md
I2C_SLAVE_REGFILE_CTRL -- requirements
Module: i2c_slave_regfile_ctrl

Interface
REQ-001 SHALL have parameter NUM_REGS, default 16: number of 8-bit registers; power of two, 2..256.
REQ-002 SHALL have parameter WP_MASK, default all-zero (NUM_REGS bits): bit i set means register i is write-protected from the I2C side.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port i2c_start, input, 1: one-cycle pulse on each address-matched START or repeated START.
REQ-006 SHALL have port i2c_rw, input, 1: direction, sampled with i2c_start; 1 = master read.
REQ-007 SHALL have port i2c_stop, input, 1: one-cycle pulse on STOP.
REQ-008 SHALL have port rx_data, input, 8: byte received from the master.
REQ-009 SHALL have port rx_valid, input, 1: one-cycle pulse qualifying rx_data.
REQ-010 SHALL have port tx_req, input, 1: one-cycle pulse when the core has consumed tx_data and needs the next byte.
REQ-011 SHALL have port tx_data, output, 8: byte the core sends on a master read.
REQ-012 SHALL have port host_addr, input, clog2(NUM_REGS): host register index.
REQ-013 SHALL have port host_wr_en, input, 1: host write strobe.
REQ-014 SHALL have port host_wr_data, input, 8: host write data.
REQ-015 SHALL have port host_rd_data, output, 8: registered read of host_addr.
REQ-016 SHALL have port host_collision, output, 1: one-cycle pulse when a host write loses arbitration.
REQ-017 SHALL have port wr_irq, output, 1: one-cycle pulse at the end of a transaction that wrote at least one register.
REQ-018 SHALL have port last_wr_ptr, output, clog2(NUM_REGS): index of the last register written from I2C.

Function
REQ-019 SHALL implement FSM states IDLE, PTR, WRITE and READ.
REQ-020 SHALL take these transitions on i2c_start: rw=0 goes to PTR; rw=1 goes to READ. This applies from any state, so repeated START is legal.
REQ-021 SHALL, in PTR, load ptr from rx_data[clog2(NUM_REGS)-1:0] on rx_valid and go to WRITE; upper bits are ignored.
REQ-022 SHALL, in WRITE, on each rx_valid: write rx_data to reg[ptr] unless WP_MASK[ptr] is set, then increment ptr.
REQ-023 SHALL skip a write-protected register silently while still incrementing ptr.
REQ-024 SHALL, on entry to READ, load tx_data with reg[ptr] on the cycle after i2c_start.
REQ-025 SHALL, in READ, on each tx_req: increment ptr and, on the next cycle, drive tx_data = reg[new ptr] (1-cycle latency).
REQ-026 SHALL wrap ptr from NUM_REGS-1 to 0.
REQ-027 SHALL drive tx_data = 8'hFF when tx_req arrives outside READ.
REQ-028 SHALL ignore rx_valid in IDLE and READ.
REQ-029 SHALL return to IDLE on i2c_stop from any state, retaining ptr.
REQ-030 SHALL pulse wr_irq on the cycle after i2c_stop if at least one unprotected I2C write occurred since the last i2c_start.
REQ-031 SHALL process start before rx_valid/tx_req when they coincide with i2c_start, and stop last when they coincide with i2c_stop.
REQ-032 SHALL give the I2C write priority over a host write in the same cycle to the same register: host write is dropped, host_collision pulses next cycle.
REQ-033 SHALL perform a host write and an I2C write to different registers in the same cycle both.
REQ-034 SHALL make host_rd_data = reg[host_addr] one cycle after host_addr is applied, showing post-write contents.
REQ-035 SHALL let host writes ignore WP_MASK.
REQ-036 SHALL update last_wr_ptr on every I2C register write, never on a host write.

Reset
REQ-037 SHALL, while rst is high, set state=IDLE, ptr=0, all registers=8'h00, tx_data=8'h00, host_rd_data=8'h00, host_collision=0, wr_irq=0, last_wr_ptr=0 and the written-flag=0.
REQ-038 SHALL abandon any transaction cut by reset mid-transfer; after release the FSM waits for i2c_start.

Structure
REQ-039 SHALL place the state enum, the default NUM_REGS and the tx idle constant 8'hFF in package i2c_regfile_pkg.
REQ-040 SHALL use one sub-module, i2c_regfile_mem: register array with a prioritized I2C write port, host write port and two read ports. FSM, ptr and flags stay in the top module.

Verification
REQ-041 SHALL cover: start rw=0, rx 0x03, 0xA5, 0x5A, stop -> reg3=A5, reg4=5A, ptr=5, wr_irq one pulse, last_wr_ptr=4.
REQ-042 SHALL cover: preset reg5=0x11, reg6=0x22; write ptr 0x05, repeated start rw=1, two tx_req -> tx_data 11, then 22, then reg7.
REQ-043 SHALL cover: ptr 0x0F, rx 0x01, 0x02 -> reg15=01, reg0=02, ptr wraps to 1.
REQ-044 SHALL cover: WP_MASK bit 2 set, ptr 0x02, rx 0x77, 0x88 -> reg2 unchanged, reg3=88; host write reg2=0x99 succeeds.
REQ-045 SHALL cover: same-cycle host write 0x33 and I2C write 0x44 to reg1 -> reg1=44, host_collision one pulse; a write to a different register is kept.
REQ-046 SHALL cover: rst asserted mid-WRITE -> all outputs at reset values, no wr_irq, later rx_valid ignored until i2c_start.
